// File: rtl/median_pkg.sv
// Shared definitions for the median-of-5 datapath (feeder and sorter).
package median_pkg;

    localparam int DATA_W = 6;
    localparam int WIN    = 5;

    // Sample count at which the next accepted sample completes a window
    localparam logic [2:0] CNT_FULL = 3'd4;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feed_state_t;

endpackage

// File: rtl/window_shift_reg.sv
// WIN-deep shift register of samples. Index 0 holds the oldest sample.
// When en is high, the newest sample enters at index WIN-1.
module window_shift_reg
    import median_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   din,
    output sample_t [WIN-1:0]   sr_q
);

    sample_t [WIN-1:0] sr_r;

    // Shift toward index 0 on each enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= '0;
        end else if (en) begin
            for (int i = 0; i < WIN - 1; i++) begin
                sr_r[i] <= sr_r[i+1];
            end
            sr_r[WIN-1] <= din;
        end
    end

    assign sr_q = sr_r;

endmodule

// File: rtl/median_window_feeder.sv
// Sliding-window feeder for the median-of-5 sorter. Collects WIN samples per
// frame, then emits one registered window per accepted sample. Windows never
// span frame boundaries; a frame shorter than WIN raises short_err.
module median_window_feeder
    import median_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [DATA_W-1:0]   win_num0,
    output logic [DATA_W-1:0]   win_num1,
    output logic [DATA_W-1:0]   win_num2,
    output logic [DATA_W-1:0]   win_num3,
    output logic [DATA_W-1:0]   win_num4,
    output logic                win_last,
    output logic                short_err
);

    feed_state_t        state_r;
    feed_state_t        state_next_s;
    logic [2:0]         cnt_r;
    logic [2:0]         cnt_next_s;
    logic               accept_s;
    logic               load_s;
    logic               load_last_s;
    logic               short_next_s;
    sample_t [WIN-1:0]  sr_s;
    sample_t [WIN-1:0]  window_s;
    sample_t [WIN-1:0]  win_num_r;
    logic               win_valid_r;
    logic               win_last_r;
    logic               short_err_r;

    // The only backpressure is an unconsumed window
    assign in_ready = !win_valid_r || win_ready;
    assign accept_s = in_valid && in_ready;

    window_shift_reg u_sr (
        .clk  (clk),
        .rst  (rst),
        .en   (accept_s),
        .din  (in_data),
        .sr_q (sr_s)
    );

    // Candidate window: the four newest held samples plus the incoming one
    always_comb begin
        for (int i = 0; i < WIN - 1; i++) begin
            window_s[i] = sr_s[i+1];
        end
        window_s[WIN-1] = in_data;
    end

    // Next-state, sample counter and window-load decisions
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        load_last_s  = 1'b0;
        short_next_s = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    if (cnt_r == CNT_FULL) begin
                        load_s       = 1'b1;
                        load_last_s  = in_last;
                        cnt_next_s   = 3'd0;
                        state_next_s = in_last ? FILL : RUN;
                    end else if (in_last) begin
                        short_next_s = 1'b1;
                        cnt_next_s   = 3'd0;
                    end else begin
                        cnt_next_s   = cnt_r + 3'd1;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            RUN: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    load_last_s = in_last;
                    if (in_last) begin
                        state_next_s = FILL;
                        cnt_next_s   = 3'd0;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = FILL;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Output window registers: load wins over retire so throughput stays full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_num_r   <= '0;
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else if (load_s) begin
            win_num_r   <= window_s;
            win_valid_r <= 1'b1;
            win_last_r  <= load_last_s;
        end else if (win_valid_r && win_ready) begin
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end
    end

    // Short-frame error pulse, one cycle after the offending last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_err_r <= 1'b0;
        end else begin
            short_err_r <= short_next_s;
        end
    end

    assign win_valid = win_valid_r;
    assign win_last  = win_last_r;
    assign short_err = short_err_r;
    assign win_num0  = win_num_r[0];
    assign win_num1  = win_num_r[1];
    assign win_num2  = win_num_r[2];
    assign win_num3  = win_num_r[3];
    assign win_num4  = win_num_r[4];

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with hand-computed windows.
module tb_median_window_feeder;
    import median_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       win_valid;
    logic       win_ready;
    logic [5:0] win_num0, win_num1, win_num2, win_num3, win_num4;
    logic       win_last;
    logic       short_err;

    int total = 0;
    int bad   = 0;

    median_window_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_num0  (win_num0),
        .win_num1  (win_num1),
        .win_num2  (win_num2),
        .win_num3  (win_num3),
        .win_num4  (win_num4),
        .win_last  (win_last),
        .short_err (short_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // valid must be 1; compares {valid,last,num0..num4} in one go
    task automatic chk_win(input string tag, input logic l,
                           input logic [5:0] e0, input logic [5:0] e1,
                           input logic [5:0] e2, input logic [5:0] e3,
                           input logic [5:0] e4);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = {win_valid, win_last, win_num0, win_num1, win_num2, win_num3, win_num4};
        exp = {1'b1, l, e0, e1, e2, e3, e4};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 6'd0;
        in_last   = 1'b0;
        win_ready = 1'b1;
        #1;
        // Reset state
        chk1("rst_valid", win_valid, 1'b0);
        chk1("rst_last", win_last, 1'b0);
        chk1("rst_short", short_err, 1'b0);
        chk1("rst_num_zero", |{win_num0, win_num1, win_num2, win_num3, win_num4}, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);

        // 1: frame 1..7 with downstream always ready
        push(6'd1, 1'b0); chk1("t1_v1", win_valid, 1'b0);
        push(6'd2, 1'b0); chk1("t1_v2", win_valid, 1'b0);
        push(6'd3, 1'b0); chk1("t1_v3", win_valid, 1'b0);
        push(6'd4, 1'b0); chk1("t1_v4", win_valid, 1'b0);
        push(6'd5, 1'b0); chk_win("t1_w1", 1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        push(6'd6, 1'b0); chk_win("t1_w2", 1'b0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
        push(6'd7, 1'b1); chk_win("t1_w3", 1'b1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7);
        idle();           chk1("t1_drain_valid", win_valid, 1'b0);
        chk1("t1_drain_last", win_last, 1'b0);

        // 2: exactly-full frame
        push(6'd9, 1'b0); push(6'd8, 1'b0); push(6'd7, 1'b0);
        push(6'd6, 1'b0); chk1("t2_v4", win_valid, 1'b0);
        push(6'd5, 1'b1); chk_win("t2_w", 1'b1, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5);
        chk1("t2_state_fill", dut.state_r == FILL, 1'b1);
        idle();           chk1("t2_drain", win_valid, 1'b0);

        // 3: short frame, then a clean full frame
        push(6'd10, 1'b0); chk1("t3_short0", short_err, 1'b0);
        push(6'd11, 1'b0);
        push(6'd12, 1'b1); chk1("t3_short_pulse", short_err, 1'b1);
        chk1("t3_no_win", win_valid, 1'b0);
        idle();            chk1("t3_short_clear", short_err, 1'b0);
        push(6'd1, 1'b0); push(6'd2, 1'b0); push(6'd3, 1'b0);
        push(6'd4, 1'b0); chk1("t3_no_stale", win_valid, 1'b0);
        push(6'd5, 1'b1); chk_win("t3_w", 1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        idle();           chk1("t3_drain", win_valid, 1'b0);

        // 4: backpressure for three cycles
        push(6'd1, 1'b0); push(6'd2, 1'b0); push(6'd3, 1'b0);
        push(6'd4, 1'b0);
        push(6'd5, 1'b0); chk_win("t4_w1", 1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'd6;
        in_last   = 1'b0;
        #1;
        chk1("t4_ready_low", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1("t4_stall_ready", in_ready, 1'b0);
            chk_win("t4_stall_win", 1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        end
        win_ready = 1'b1;
        #1;
        chk1("t4_ready_back", in_ready, 1'b1);
        @(posedge clk); #1;
        chk_win("t4_w2", 1'b0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
        push(6'd7, 1'b1); chk_win("t4_w3", 1'b1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7);
        idle();           chk1("t4_drain", win_valid, 1'b0);

        // 5: 20-sample frame at full throughput, 16 back-to-back windows
        for (int i = 0; i < 20; i++) begin
            push(6'(40 + i), (i == 19));
            if (i < 4) begin
                chk1("t5_fill", win_valid, 1'b0);
            end else begin
                chk_win("t5_win", (i == 19), 6'(36 + i), 6'(37 + i),
                        6'(38 + i), 6'(39 + i), 6'(40 + i));
            end
        end
        idle(); chk1("t5_drain", win_valid, 1'b0);

        // 6: reset mid-frame drops everything
        push(6'd1, 1'b0); push(6'd2, 1'b0); push(6'd3, 1'b0);
        rst = 1'b1;
        #1;
        chk1("t6_valid0", win_valid, 1'b0);
        chk1("t6_nums0", |{win_num0, win_num1, win_num2, win_num3, win_num4}, 1'b0);
        chk1("t6_last0", win_last, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk1("t6_in_ready", in_ready, 1'b1);
        push(6'd20, 1'b0); chk1("t6_no_short", short_err, 1'b0);
        push(6'd21, 1'b0); push(6'd22, 1'b0);
        push(6'd23, 1'b0); chk1("t6_v4", win_valid, 1'b0);
        push(6'd24, 1'b1); chk_win("t6_w", 1'b1, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24);
        idle();            chk1("t6_drain", win_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
